// File: rtl/sap_pkg.sv
// Purpose : Shared SAP-1 constants for the timing decoder, control matrix and IR.
// Contents: ring/opcode widths, opcode encodings, T-state bit indices,
//           instruction enum, opcode decode and one-hot check helpers.
package sap_pkg;

    localparam int unsigned NUM_T = 6;
    localparam int unsigned OPC_W = 4;

    localparam logic [OPC_W-1:0] RST_OPC = 4'b1101;
    localparam logic [OPC_W-1:0] OPC_LDA = 4'h0;
    localparam logic [OPC_W-1:0] OPC_ADD = 4'h1;
    localparam logic [OPC_W-1:0] OPC_SUB = 4'h2;
    localparam logic [OPC_W-1:0] OPC_OUT = 4'hE;
    localparam logic [OPC_W-1:0] OPC_HLT = 4'hF;

    localparam int unsigned T1_IDX = 0;
    localparam int unsigned T2_IDX = 1;
    localparam int unsigned T3_IDX = 2;
    localparam int unsigned T4_IDX = 3;
    localparam int unsigned T5_IDX = 4;
    localparam int unsigned T6_IDX = 5;

    typedef enum logic [2:0] {
        INSTR_NOP,
        INSTR_LDA,
        INSTR_ADD,
        INSTR_SUB,
        INSTR_OUT,
        INSTR_HLT
    } instr_e;

    // Map an opcode nibble onto its instruction class.
    function automatic instr_e decode_opc(input logic [OPC_W-1:0] opc);
        instr_e res;
        unique case (opc)
            OPC_LDA: res = INSTR_LDA;
            OPC_ADD: res = INSTR_ADD;
            OPC_SUB: res = INSTR_SUB;
            OPC_OUT: res = INSTR_OUT;
            OPC_HLT: res = INSTR_HLT;
            default: res = INSTR_NOP;
        endcase
        return res;
    endfunction

    // True when exactly one bit of the ring is set.
    function automatic logic is_onehot(input logic [NUM_T-1:0] v);
        return (v != '0) && ((v & (v - NUM_T'(1))) == '0);
    endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// Purpose : One-hot T-state rotator with enable, async clear, halt-to-zero
//           and resync of any corrupt (non one-hot) state back to T1.
// Ports   : clk, clr (async, active-high), i_adv (rotate enable),
//           i_zero (force ring to all-zero, used for halt), o_ring (bit0 = T1).
module sap_ring_counter
    import sap_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             i_adv,
    input  logic             i_zero,
    output logic [NUM_T-1:0] o_ring
);

    logic [NUM_T-1:0] r_ring;

    // Halt dominates resync so the all-zero halted ring is never "repaired".
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_ring <= NUM_T'(1);
        end else if (i_zero) begin
            r_ring <= '0;
        end else if (!is_onehot(r_ring)) begin
            r_ring <= NUM_T'(1);
        end else if (i_adv) begin
            r_ring <= {r_ring[NUM_T-2:0], r_ring[NUM_T-1]};
        end
    end

    assign o_ring = r_ring;

endmodule

// File: rtl/sap_timing_decoder.sv
// Purpose : SAP-1 timing generator and instruction decoder.
// Ports   : clk, clr (async, active-high), run, step, bus_opc (W-bus nibble);
//           t1..t6 one-hot T-states (flop outputs), lda/add/sub/out/nop
//           instruction flags valid in T4..T6, hlt sticky halt,
//           ring_adv one-cycle pulse after each advancing edge.
module sap_timing_decoder
    import sap_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic             step,
    input  logic [OPC_W-1:0] bus_opc,
    output logic             t1,
    output logic             t2,
    output logic             t3,
    output logic             t4,
    output logic             t5,
    output logic             t6,
    output logic             lda,
    output logic             add,
    output logic             sub,
    output logic             out,
    output logic             hlt,
    output logic             nop,
    output logic             ring_adv
);

    logic [NUM_T-1:0] w_ring;
    logic [OPC_W-1:0] r_opc;
    logic             r_halt;
    logic             r_ring_adv;
    logic             w_adv;
    logic             w_halt_set;
    logic             w_exec;

    // run already advances every edge, so step only matters when run=0.
    assign w_adv      = !r_halt && (run || step);
    // Halt is taken on the edge leaving T3 that loads an HLT opcode.
    assign w_halt_set = w_adv && t3 && (bus_opc == OPC_HLT);

    sap_ring_counter u_ring (
        .clk    (clk),
        .clr    (clr),
        .i_adv  (w_adv),
        .i_zero (r_halt || w_halt_set),
        .o_ring (w_ring)
    );

    assign {t6, t5, t4, t3, t2, t1} = w_ring;

    // Opcode latch, sticky halt and advance strobe.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_opc      <= RST_OPC;
            r_halt     <= 1'b0;
            r_ring_adv <= 1'b0;
        end else begin
            r_ring_adv <= w_adv;
            if (w_adv && t3) begin
                r_opc <= bus_opc;
            end
            if (w_halt_set) begin
                r_halt <= 1'b1;
            end
        end
    end

    assign w_exec = t4 || t5 || t6;

    // Instruction flags, gated to the execute states T4..T6.
    always_comb begin
        lda = 1'b0;
        add = 1'b0;
        sub = 1'b0;
        out = 1'b0;
        nop = 1'b0;
        if (w_exec) begin
            unique case (decode_opc(r_opc))
                INSTR_LDA: lda = 1'b1;
                INSTR_ADD: add = 1'b1;
                INSTR_SUB: sub = 1'b1;
                INSTR_OUT: out = 1'b1;
                INSTR_HLT: nop = 1'b0;
                default:   nop = 1'b1;
            endcase
        end
    end

    assign hlt      = r_halt;
    assign ring_adv = r_ring_adv;

endmodule

// File: tb/tb_sap_timing_decoder.sv
// Purpose : Self-checking bench for sap_timing_decoder; a state-index model
//           of the SAP-1 timing rules is compared with the DUT every cycle.
module tb_sap_timing_decoder;

    logic       clk = 1'b0;
    logic       clr;
    logic       run;
    logic       step;
    logic [3:0] bus_opc;
    logic       t1, t2, t3, t4, t5, t6;
    logic       lda, add, sub, out, hlt, nop, ring_adv;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: current T-state number (1..6), latched opcode, halt, strobe.
    bit       m_halt;
    int       m_t;
    bit [3:0] m_opc;
    bit       m_radv;

    always #5 clk = ~clk;

    sap_timing_decoder dut (
        .clk      (clk),
        .clr      (clr),
        .run      (run),
        .step     (step),
        .bus_opc  (bus_opc),
        .t1       (t1),
        .t2       (t2),
        .t3       (t3),
        .t4       (t4),
        .t5       (t5),
        .t6       (t6),
        .lda      (lda),
        .add      (add),
        .sub      (sub),
        .out      (out),
        .hlt      (hlt),
        .nop      (nop),
        .ring_adv (ring_adv)
    );

    // Bit order: t1..t6, lda, add, sub, out, hlt, nop, ring_adv.
    function automatic logic [12:0] dut_vec();
        return {t1, t2, t3, t4, t5, t6, lda, add, sub, out, hlt, nop, ring_adv};
    endfunction

    function automatic logic [12:0] model_vec();
        logic [12:0] v;
        v = '0;
        if (!m_halt) v[13 - m_t] = 1'b1;
        if (!m_halt && m_t >= 4) begin
            case (m_opc)
                4'h0:    v[6] = 1'b1;
                4'h1:    v[5] = 1'b1;
                4'h2:    v[4] = 1'b1;
                4'hE:    v[3] = 1'b1;
                default: v[1] = 1'b1;
            endcase
        end
        v[2] = m_halt;
        v[0] = m_radv;
        return v;
    endfunction

    task automatic check(input string name, input logic [12:0] exp);
        logic [12:0] got;
        got = dut_vec();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_halt = 1'b0;
        m_t    = 1;
        m_opc  = 4'hD;
        m_radv = 1'b0;
    endtask

    // Apply the rules for one rising edge using the currently driven inputs.
    task automatic model_edge();
        bit adv;
        adv    = !m_halt && (run || step);
        m_radv = adv;
        if (adv) begin
            if (m_t == 3) begin
                m_opc = bus_opc;
                if (bus_opc == 4'hF) m_halt = 1'b1;
            end
            m_t = (m_t == 6) ? 1 : m_t + 1;
        end
    endtask

    task automatic do_cycle(input bit r, input bit s, input logic [3:0] b);
        @(negedge clk);
        check("cycle", model_vec());
        run     = r;
        step    = s;
        bus_opc = b;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle asynchronous clear; released before the next edge with run=0.
    task automatic do_clr();
        @(negedge clk);
        #1 clr = 1'b1;
        model_reset();
        #1;
        check("clr_async", 13'b100000_000000_0);
        check("clr_model", model_vec());
        clr  = 1'b0;
        run  = 1'b0;
        step = 1'b0;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [3:0] opc);
        for (int k = 0; k < 6; k++) do_cycle(1'b1, 1'b0, opc);
    endtask

    initial begin
        clr     = 1'b1;
        run     = 1'b0;
        step    = 1'b0;
        bus_opc = 4'h0;
        model_reset();
        @(negedge clk);
        check("reset", 13'b100000_000000_0);
        #1 clr = 1'b0;
        model_edge();
        @(posedge clk);
        #1;

        // LDA: T1,T2,T3 with opcode 0 on the bus, then T4 shows lda.
        do_cycle(1'b1, 1'b0, 4'h0);
        do_cycle(1'b1, 1'b0, 4'h0);
        do_cycle(1'b1, 1'b0, 4'h0);
        check("lda_t4", 13'b000100_100000_1);
        do_cycle(1'b1, 1'b0, 4'h0);
        do_cycle(1'b1, 1'b0, 4'h0);
        do_cycle(1'b1, 1'b0, 4'h0);
        check("wrap_t1", 13'b100000_000000_1);

        // ADD then OUT back to back.
        run_instr(4'h1);
        run_instr(4'hE);
        for (int k = 0; k < 4; k++) do_cycle(1'b1, 1'b0, 4'h6);
        check("nop_t5", 13'b000010_000001_1);

        // Clear while in T5.
        do_clr();

        // Single-step: pulses on cycles 3 and 7 only.
        for (int c = 1; c <= 9; c++) begin
            do_cycle(1'b0, (c == 3) || (c == 7), 4'h2);
            n_checks++;
            if (ring_adv !== ((c + 1 == 4) || (c + 1 == 8))) begin
                n_fail++;
                $display("FAIL step_ring_adv cycle %0d: got %b", c + 1, ring_adv);
            end
        end
        check("step_t3", 13'b001000_000000_0);

        // Halt: load 1111 at T3 and confirm run/step cannot revive the ring.
        do_clr();
        do_cycle(1'b1, 1'b0, 4'h0);
        do_cycle(1'b1, 1'b0, 4'h0);
        do_cycle(1'b1, 1'b0, 4'hF);
        check("halt_enter", 13'b000000_000010_1);
        for (int k = 0; k < 20; k++) do_cycle(1'b1, 1'($urandom_range(0, 1)), 4'($urandom));
        check("halt_hold", 13'b000000_000010_0);
        do_clr();

        // Random traffic with occasional clears.
        for (int k = 0; k < 600; k++) begin
            logic [3:0] b;
            if ($urandom_range(0, 39) == 0) begin
                do_clr();
            end else begin
                b = 4'($urandom);
                if (b == 4'hF && $urandom_range(0, 5) != 0) b = 4'h6;
                do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, b);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
